tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-slot time-division demultiplexer: the receive end of a 4:1 mux link. A source drives one shared data line through a 4-to-1 mux whose select counts slots 0..3. This block recovers frame alignment from a slot-0 sync marker, routes each sample to its slot, and publishes all four slots together as a registered, frame-coherent word set with a one-cycle valid pulse.

## Interface
Parameters:
- WIDTH, 1, bits per slot sample on din and on each y output.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  shared multiplexed data line.
- sync  input  1  high with the slot-0 sample of each frame; qualified by en.
- en  input  1  sample strobe; din and sync are sampled only when en=1.
- y0, y1, y2, y3  output  WIDTH each  last complete frame, slot 0..3.
- slot  output  2  slot index the next qualified sample will be stored as.
- frame_valid  output  1  one-cycle pulse when y0..y3 are updated.
- locked  output  1  high while the frame state machine is LOCKED.
- sync_err  output  1  one-cycle pulse on any sync/slot disagreement.

## Operation
- State machine: HUNT and LOCKED. Shadow registers sh0..sh2 hold slots 0..2 of the frame in progress.
- HUNT: qualified sample with sync=0 is discarded. Qualified sample with sync=1: din goes to sh0, slot becomes 1, state becomes LOCKED.
- LOCKED, qualified sample, slot=1 or 2, sync=0: din goes to sh[slot], slot increments.
- LOCKED, qualified sample, slot=3, sync=0:
  - y0..y2 load from sh0..sh2; y3 loads din.
  - frame_valid pulses; slot wraps to 0.
- LOCKED, qualified sample, slot=0, sync=1: din goes to sh0, slot becomes 1.
- LOCKED, qualified sample, slot=1..3, sync=1 (early sync):
  - sync_err pulses; the partial frame is discarded and y is unchanged.
  - The sample is taken as a new slot 0: din goes to sh0, slot becomes 1.
- LOCKED, qualified sample, slot=0, sync=0 (missing sync):
  - sync_err pulses.
  - Without TDM_DEMUX_FLYWHEEL_EN: state becomes HUNT, the sample is discarded, slot stays 0.
- en=0: no state, slot, shadow or y change.
- y0..y3 only ever change together, and only from a complete four-slot frame.
- Data is passed unmodified; no arithmetic on din.

## Timing
- Reset (asynchronous, on rst_n low): y0..y3=0, slot=0, frame_valid=0, locked=0, sync_err=0, state HUNT, shadows=0.
- Reset asserted mid-frame discards the partial frame; y is not updated.
- Latency: y0..y3 and frame_valid are visible after the same rising edge that samples slot 3.
  - frame_valid is high for exactly one cycle, even if en is then held low.
- sync_err is high for exactly one cycle after the offending edge.
- locked is registered: it is high after the edge that leaves HUNT and low after the edge that enters HUNT.
- Back-to-back frames with en held high give one frame_valid every 4 cycles.
- Minimum acquisition: sync on the first qualified sample gives the first frame_valid 4 edges later.

## Configuration
- TDM_DEMUX_FLYWHEEL_EN defined:
  - A missing sync at slot 0 in LOCKED is tolerated once. sync_err pulses, the sample goes to sh0 as slot 0, slot becomes 1, state stays LOCKED, and that frame is published normally.
  - A second consecutive missing sync returns to HUNT and discards the sample.
  - The miss count is a 1-bit flag, cleared by any correctly synced slot 0 or by reset.
- Not defined: the first missing sync returns to HUNT. The flag register is not built.

## Test plan
- Reset: hold rst_n=0, toggle din/sync/en. Required: all outputs 0 and locked=0 throughout. Release rst_n, then apply no sync. Required: locked stays 0 and no frame_valid.
- Aligned frames, WIDTH=1, en=1, sync on first sample of each frame:
  - Frame 1,0,0,0: y0..y3=1,0,0,0, frame_valid one cycle after 4th edge, locked=1.
  - Frame 0,1,1,1: y=0,1,1,1.
  - Frame 1,0,1,1: y=1,0,1,1.
  - Pulses exactly 4 cycles apart.
- en gaps: frame 0,0,1,0 with en=0 for 3 cycles between slots 1 and 2. Required: slot holds at 2, y unchanged until slot 3 is sampled, then y=0,0,1,0 with a single frame_valid.
- Early sync: sync at slot 2 of a partial frame. Required: sync_err one cycle, no frame_valid, y keeps the previous frame. Next 4-sample frame publishes normally.
- Missing sync:
  - Without macro: sync=0 at slot 0 gives sync_err, then locked=0, and the next frame needs sync to reacquire.
  - With TDM_DEMUX_FLYWHEEL_EN: one miss gives sync_err, locked stays 1 and the frame is published. Two consecutive misses give locked=0.
- Reset mid-frame: assert rst_n low after slot 2 of frame 1,1,1,0. Required: y=0 immediately, no frame_valid, slot=0, locked=0.

Source files
------------

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: locks to a slot-0 sync marker, publishes y0..y3 per complete frame.
// Optional TDM_DEMUX_FLYWHEEL_EN tolerates one missing sync at slot 0 before dropping lock.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             sync,
  input  logic             en,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [1:0]       slot,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
`ifdef TDM_DEMUX_FLYWHEEL_EN
  logic             miss_q, miss_d;
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
`ifdef TDM_DEMUX_FLYWHEEL_EN
    miss_d  = miss_q;
`endif
    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            sh0_d   = din;
            slot_d  = 2'd1;
            state_d = LOCKED;
`ifdef TDM_DEMUX_FLYWHEEL_EN
            miss_d  = 1'b0;
`endif
          end
        end
        LOCKED: begin
          if (sync) begin
            // Any sync restarts the frame at slot 0; mid-frame it also flags an error.
            err_d  = (slot_q != 2'd0);
            sh0_d  = din;
            slot_d = 2'd1;
`ifdef TDM_DEMUX_FLYWHEEL_EN
            miss_d = 1'b0;
`endif
          end else begin
            case (slot_q)
              2'd0: begin
                err_d = 1'b1;
`ifdef TDM_DEMUX_FLYWHEEL_EN
                if (!miss_q) begin
                  sh0_d  = din;
                  slot_d = 2'd1;
                  miss_d = 1'b1;
                end else begin
                  state_d = HUNT;
                  miss_d  = 1'b0;
                end
`else
                state_d = HUNT;
`endif
              end
              2'd1: begin
                sh1_d  = din;
                slot_d = 2'd2;
              end
              2'd2: begin
                sh2_d  = din;
                slot_d = 2'd3;
              end
              default: begin
                y0_d   = sh0_q;
                y1_d   = sh1_q;
                y2_d   = sh2_q;
                y3_d   = din;
                fv_d   = 1'b1;
                slot_d = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

`ifdef TDM_DEMUX_FLYWHEEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miss_q <= 1'b0;
    else        miss_q <= miss_d;
  end
`endif

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign slot        = slot_q;
  assign frame_valid = fv_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=1); expectations follow TDM_DEMUX_FLYWHEEL_EN.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din;
  logic       sync, en;
  logic [0:0] y0, y1, y2, y3;
  logic [1:0] slot;
  logic       frame_valid, locked, sync_err;
  logic [3:0] ybus;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sync(sync), .en(en),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .slot(slot),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  assign ybus = {y0, y1, y2, y3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic s, input logic e);
    din  = d;
    sync = s;
    en   = e;
    @(posedge clk);
    #1;
  endtask

  // Expect: y changes only on the fourth sample, with a single frame_valid.
  task automatic frame(input logic [3:0] b, input logic [3:0] y_prev, input string tag);
    step(b[3], 1'b1, 1'b1);
    chk({tag, "_s0_locked"}, 32'(locked), 32'd1);
    chk({tag, "_s0_slot"}, 32'(slot), 32'd1);
    chk({tag, "_s0_fv"}, 32'(frame_valid), 32'd0);
    chk({tag, "_s0_err"}, 32'(sync_err), 32'd0);
    step(b[2], 1'b0, 1'b1);
    chk({tag, "_s1_fv"}, 32'(frame_valid), 32'd0);
    step(b[1], 1'b0, 1'b1);
    chk({tag, "_s2_fv"}, 32'(frame_valid), 32'd0);
    chk({tag, "_s2_y"}, 32'(ybus), 32'(y_prev));
    step(b[0], 1'b0, 1'b1);
    chk({tag, "_s3_fv"}, 32'(frame_valid), 32'd1);
    chk({tag, "_s3_y"}, 32'(ybus), 32'(b));
    chk({tag, "_s3_slot"}, 32'(slot), 32'd0);
    chk({tag, "_s3_err"}, 32'(sync_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; sync = 1'b0; en = 1'b0;
    // Reset held: outputs stay zero while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      step(1'(i), 1'(~i), 1'b1);
      chk("rst_y", 32'(ybus), 32'd0);
      chk("rst_slot", 32'(slot), 32'd0);
      chk("rst_fv", 32'(frame_valid), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err", 32'(sync_err), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("hunt_locked", 32'(locked), 32'd0);
      chk("hunt_fv", 32'(frame_valid), 32'd0);
      chk("hunt_slot", 32'(slot), 32'd0);
    end

    // Aligned back-to-back frames.
    frame(4'b1000, 4'b0000, "f1");
    frame(4'b0111, 4'b1000, "f2");
    frame(4'b1011, 4'b0111, "f3");

    // en gap between slots 1 and 2 of frame 0,0,1,0.
    step(1'b0, 1'b1, 1'b1);
    chk("gap_fv_clear", 32'(frame_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("gap_slot2", 32'(slot), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'(i), 1'b1, 1'b0);
      chk("gap_hold_slot", 32'(slot), 32'd2);
      chk("gap_hold_y", 32'(ybus), 32'b1011);
      chk("gap_hold_fv", 32'(frame_valid), 32'd0);
      chk("gap_hold_err", 32'(sync_err), 32'd0);
    end
    step(1'b1, 1'b0, 1'b1);
    chk("gap_slot3", 32'(slot), 32'd3);
    chk("gap_pre_y", 32'(ybus), 32'b1011);
    step(1'b0, 1'b0, 1'b1);
    chk("gap_fv", 32'(frame_valid), 32'd1);
    chk("gap_y", 32'(ybus), 32'b0010);
    step(1'b1, 1'b0, 1'b0);
    chk("gap_fv_one_cycle", 32'(frame_valid), 32'd0);
    chk("gap_y_hold", 32'(ybus), 32'b0010);

    // Early sync at slot 2 restarts the frame; the resync sample becomes slot 0.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("early_slot2", 32'(slot), 32'd2);
    step(1'b0, 1'b1, 1'b1);
    chk("early_err", 32'(sync_err), 32'd1);
    chk("early_fv", 32'(frame_valid), 32'd0);
    chk("early_slot", 32'(slot), 32'd1);
    chk("early_y", 32'(ybus), 32'b0010);
    chk("early_locked", 32'(locked), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("early_err_clear", 32'(sync_err), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("early_next_fv", 32'(frame_valid), 32'd1);
    chk("early_next_y", 32'(ybus), 32'b0101);

    // Missing sync at slot 0.
    step(1'b1, 1'b0, 1'b1);
    chk("miss1_err", 32'(sync_err), 32'd1);
`ifdef TDM_DEMUX_FLYWHEEL_EN
    chk("miss1_locked", 32'(locked), 32'd1);
    chk("miss1_slot", 32'(slot), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("miss1_err_clear", 32'(sync_err), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("miss1_fv", 32'(frame_valid), 32'd1);
    chk("miss1_y", 32'(ybus), 32'b1011);
    step(1'b1, 1'b0, 1'b1);
    chk("miss2_err", 32'(sync_err), 32'd1);
    chk("miss2_locked", 32'(locked), 32'd0);
    chk("miss2_slot", 32'(slot), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("miss2_stay_hunt", 32'(locked), 32'd0);
    chk("miss2_err_clear", 32'(sync_err), 32'd0);
    frame(4'b1100, 4'b1011, "reacq");
`else
    chk("miss_locked", 32'(locked), 32'd0);
    chk("miss_slot", 32'(slot), 32'd0);
    chk("miss_fv", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("miss_stay_hunt", 32'(locked), 32'd0);
    chk("miss_err_clear", 32'(sync_err), 32'd0);
    chk("miss_y_hold", 32'(ybus), 32'b0101);
    frame(4'b1100, 4'b0101, "reacq");
`endif

    // Reset asserted mid-frame (after slot 2 of 1,1,1,0).
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("mid_slot3", 32'(slot), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y", 32'(ybus), 32'd0);
    chk("mid_rst_slot", 32'(slot), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_fv", 32'(frame_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("mid_rst_fv_edge", 32'(frame_valid), 32'd0);
    chk("mid_rst_y_edge", 32'(ybus), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    chk("post_rst_fv", 32'(frame_valid), 32'd0);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_y", 32'(ybus), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
